dual_helix_obi2apb_bridge: RTL and testbench

Downstream of a cv32e40p data port. Converts the core's OBI-style data bus (req/gnt/rvalid) into a single APB4 master transaction toward the peripheral segment. One transaction is in flight at a time. Requests outside the bridge's address window, and APB accesses that stall too long, return an error response to the core instead of hanging it.

---
 rtl/dual_helix_obi2apb_bridge.sv | 140 ++++++++++++++
 tb/tb_dual_helix_obi2apb_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_helix_obi2apb_bridge.sv
// OBI (req/gnt/rvalid) to APB4 bridge: one transaction in flight, out-of-window
// requests and stalled APB accesses are answered with an error response.
module dual_helix_obi2apb_bridge #(
    parameter logic [31:0] ADDR_BASE      = 32'h4000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFF0_0000,
    parameter int unsigned APB_ADDR_WIDTH = 20,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_addr_i,
    input  logic [31:0]               data_wdata_i,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [31:0]               pwdata_o,
    output logic [3:0]                pstrb_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      pwrite_q;
    logic [31:0]               pwdata_q;
    logic [3:0]                pstrb_q;
    logic                      rvalid_q;
    logic [31:0]               rdata_q;
    logic                      err_q;

    logic in_window;
    logic timeout_hit;

    assign in_window   = (data_addr_i & ADDR_MASK) == ADDR_BASE;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    // Reset gates the grant so no handshake can land on a reset edge.
    assign data_gnt_o  = data_req_i && rst_ni && (state_q == IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_gnt_o) begin
                        if (in_window) begin
                            state_q   <= SETUP;
                            cnt_q     <= '0;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            paddr_q   <= data_addr_i[APB_ADDR_WIDTH-1:0];
                            pwrite_q  <= data_we_i;
                            pwdata_q  <= data_wdata_i;
                            pstrb_q   <= data_we_i ? data_be_i : 4'b0000;
                        end else begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                            err_q    <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A ready that coincides with expiry is a normal completion.
                    if (pready_i) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= pwrite_q ? 32'h0 : prdata_i;
                        err_q     <= pslverr_i;
                    end else if (timeout_hit) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign paddr_o       = paddr_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;

endmodule

// File: tb/tb_dual_helix_obi2apb_bridge.sv
// Self-checking bench for the OBI-to-APB bridge, run with a short timeout window.
module tb_dual_helix_obi2apb_bridge;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] MASK = 32'hFFF0_0000;
    localparam int          TO   = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [19:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    dual_helix_obi2apb_bridge #(
        .ADDR_BASE     (BASE),
        .ADDR_MASK     (MASK),
        .APB_ADDR_WIDTH(20),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .paddr_o      (paddr_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .pwdata_o     (pwdata_o),
        .pstrb_o      (pstrb_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i)
    );

    // Reference: slave answers on ACCESS cycle waits+1 unless the window of TO cycles runs out.
    function automatic void model(input logic [31:0] addr, input logic we, input int waits,
                                  input logic [31:0] prd, input logic serr,
                                  output int lat, output logic [31:0] rd, output logic er,
                                  output int acc);
        if ((addr & MASK) != BASE) begin
            lat = 1; rd = 32'h0; er = 1'b1; acc = 0;
        end else if (waits < TO) begin
            acc = waits + 1; lat = acc + 2; rd = we ? 32'h0 : prd; er = serr;
        end else begin
            acc = TO; lat = TO + 2; rd = 32'h0; er = 1'b1;
        end
    endfunction

    // Drives one request and plays the APB slave; starts and ends on a falling edge.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input int waits, input logic [31:0] prd,
                          input logic serr,
                          output bit got, output int lat, output logic [31:0] rd,
                          output logic er, output int acc, output int setup,
                          output bit stable, output logic psel_rv,
                          output logic [19:0] o_paddr, output logic o_pwrite,
                          output logic [31:0] o_pwdata, output logic [3:0] o_pstrb);
        int n;
        bit seen;
        got = 0; lat = 0; rd = 'x; er = 'x; acc = 0; setup = 0; stable = 1; psel_rv = 'x;
        o_paddr = '0; o_pwrite = 0; o_pwdata = '0; o_pstrb = '0; seen = 0;
        data_req_i = 1; data_addr_i = addr; data_we_i = we; data_be_i = be; data_wdata_i = wd;
        #1;
        n = 0;
        while (!data_gnt_o && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        if (!data_gnt_o) begin
            data_req_i = 0;
            return;
        end
        @(negedge clk_i);
        data_req_i = 0; data_addr_i = $urandom; data_wdata_i = $urandom; data_be_i = 4'($urandom);
        lat = 1;
        for (int i = 0; i < 64; i++) begin
            if (psel_o) begin
                if (!seen) begin
                    o_paddr = paddr_o; o_pwrite = pwrite_o; o_pwdata = pwdata_o; o_pstrb = pstrb_o;
                    seen = 1;
                end else if (paddr_o !== o_paddr || pwrite_o !== o_pwrite ||
                             pwdata_o !== o_pwdata || pstrb_o !== o_pstrb) begin
                    stable = 0;
                end
            end
            if (psel_o && !penable_o) setup++;
            if (psel_o && penable_o) begin
                acc++;
                pready_i = (acc == waits + 1); prdata_i = prd; pslverr_i = serr;
            end else begin
                pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
            end
            if (data_rvalid_o) begin
                rd = data_rdata_o; er = data_err_o; psel_rv = psel_o; got = 1;
                break;
            end
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 0; data_req_i = 1; data_addr_i = BASE; data_we_i = 0; data_be_i = 4'hF;
        data_wdata_i = 32'h0; pready_i = 1; pslverr_i = 0; prdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (data_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", data_gnt_o); end
        checks++;
        if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, data_rvalid_o, data_rdata_o, data_err_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h rv=%b rdata=%h err=%b",
                     psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, data_rvalid_o, data_rdata_o, data_err_o);
        end
        data_req_i = 0;
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
    endtask

    task automatic test_read_basic();
        bit got, st; int lat, acc, su; logic [31:0] rd, pwd; logic er, prv, pw; logic [19:0] pa; logic [3:0] ps;
        do_txn(32'h4000_0010, 0, 4'hF, 32'h5555_0000, 0, 32'hDEAD_BEEF, 0,
               got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
        checks++;
        if (!got || lat != 3) begin failures++; $display("FAIL read_latency got=%0d lat=%0d exp=3", got, lat); end
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin failures++; $display("FAIL read_data rdata=%h err=%b exp=deadbeef/0", rd, er); end
        checks++;
        if (pa !== 20'h00010 || ps !== 4'h0 || pw !== 1'b0 || su != 1 || acc != 1) begin
            failures++; $display("FAIL read_apb paddr=%h pstrb=%h pwrite=%b setup=%0d acc=%0d", pa, ps, pw, su, acc);
        end
        @(negedge clk_i);
        checks++;
        if (data_rvalid_o !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b exp=0", data_rvalid_o); end
    endtask

    task automatic test_write_waits();
        bit got, st; int lat, acc, su; logic [31:0] rd, pwd; logic er, prv, pw; logic [19:0] pa; logic [3:0] ps;
        // Ready arrives on the fourth ACCESS cycle, the same cycle the window would expire.
        do_txn(32'h4001_0004, 1, 4'b0110, 32'h1234_5678, 3, 32'hFFFF_FFFF, 0,
               got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
        checks++;
        if (!got || lat != 6 || acc != 4) begin failures++; $display("FAIL write_latency got=%0d lat=%0d acc=%0d exp=6/4", got, lat, acc); end
        checks++;
        if (pw !== 1'b1 || ps !== 4'b0110 || pwd !== 32'h1234_5678 || pa !== 20'h10004 || !st) begin
            failures++; $display("FAIL write_apb pwrite=%b pstrb=%b pwdata=%h paddr=%h stable=%0d", pw, ps, pwd, pa, st);
        end
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL write_resp err=%b rdata=%h exp=0/0", er, rd); end
    endtask

    task automatic test_out_of_window();
        bit got, st; int lat, acc, su; logic [31:0] rd, pwd; logic er, prv, pw; logic [19:0] pa; logic [3:0] ps;
        do_txn(32'h5000_0000, 0, 4'hF, 32'h0, 0, 32'h1111_1111, 0,
               got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
        checks++;
        if (!got || lat != 1 || acc != 0 || su != 0) begin
            failures++; $display("FAIL oow_latency got=%0d lat=%0d setup=%0d acc=%0d exp=1/0/0", got, lat, su, acc);
        end
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL oow_resp err=%b rdata=%h exp=1/0", er, rd); end
    endtask

    task automatic test_timeout();
        bit got, st; int lat, acc, su; logic [31:0] rd, pwd; logic er, prv, pw; logic [19:0] pa; logic [3:0] ps;
        do_txn(32'h4000_0100, 0, 4'hF, 32'h0, 1000, 32'h7777_7777, 0,
               got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
        checks++;
        if (!got || acc != TO || lat != TO + 2) begin
            failures++; $display("FAIL timeout_cycles got=%0d acc=%0d lat=%0d exp=%0d/%0d", got, acc, lat, TO, TO + 2);
        end
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || prv !== 1'b0) begin
            failures++; $display("FAIL timeout_resp err=%b rdata=%h psel=%b exp=1/0/0", er, rd, prv);
        end
        do_txn(32'h4000_0200, 0, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 0,
               got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
        checks++;
        if (!got || lat != 4 || rd !== 32'h0BAD_F00D || er !== 1'b0) begin
            failures++; $display("FAIL after_timeout got=%0d lat=%0d rdata=%h err=%b exp=4/0badf00d/0", got, lat, rd, er);
        end
    endtask

    task automatic test_slverr();
        bit got, st; int lat, acc, su; logic [31:0] rd, pwd; logic er, prv, pw; logic [19:0] pa; logic [3:0] ps;
        do_txn(32'h4000_0020, 0, 4'hF, 32'h0, 0, 32'hAAAA_AAAA, 1,
               got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
        checks++;
        if (!got || er !== 1'b1 || rd !== 32'hAAAA_AAAA) begin
            failures++; $display("FAIL slverr got=%0d err=%b rdata=%h exp=1/aaaaaaaa", got, er, rd);
        end
    endtask

    task automatic test_back_to_back(input logic [31:0] addr, input int spacing, input string tag);
        int gnts[$];
        int bad;
        data_req_i = 1; data_addr_i = addr; data_we_i = 0; data_be_i = 4'hF; data_wdata_i = 32'h0;
        for (int c = 0; c < 17; c++) begin
            pready_i = (psel_o && penable_o) ? 1'b1 : 1'($urandom);
            pslverr_i = 0; prdata_i = $urandom;
            #1;
            if (data_gnt_o) gnts.push_back(c);
            @(negedge clk_i);
        end
        data_req_i = 0;
        bad = 0;
        for (int i = 1; i < gnts.size(); i++) if (gnts[i] - gnts[i-1] != spacing) bad++;
        checks++;
        if (gnts.size() < 16 / spacing || bad != 0) begin
            failures++; $display("FAIL b2b_%s grants=%0d bad_gaps=%0d exp_spacing=%0d", tag, gnts.size(), bad, spacing);
        end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset_during_access();
        bit got, st; int lat, acc, su, n, rv; logic [31:0] rd, pwd; logic er, prv, pw; logic [19:0] pa; logic [3:0] ps;
        data_req_i = 1; data_addr_i = 32'h4000_0300; data_we_i = 0; data_be_i = 4'hF; pready_i = 0;
        #1;
        n = 0;
        while (!(psel_o && penable_o) && n < 10) begin
            @(negedge clk_i); data_req_i = 0; pready_i = 0; n++;
        end
        checks++;
        if (!(psel_o && penable_o)) begin failures++; $display("FAIL rst_access_reach psel=%b pen=%b exp=1/1", psel_o, penable_o); end
        rst_ni = 0;
        @(negedge clk_i);
        checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
            failures++; $display("FAIL rst_abort psel=%b pen=%b rvalid=%b exp=0/0/0", psel_o, penable_o, data_rvalid_o);
        end
        rst_ni = 1; rv = 0;
        repeat (5) begin
            pready_i = 1'($urandom);
            @(negedge clk_i);
            if (data_rvalid_o) rv++;
        end
        checks++;
        if (rv != 0) begin failures++; $display("FAIL rst_no_rvalid pulses=%0d exp=0", rv); end
        do_txn(32'h4000_0044, 0, 4'hF, 32'h0, 0, 32'hC0DE_0001, 0,
               got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
        checks++;
        if (!got || lat != 3 || rd !== 32'hC0DE_0001 || er !== 1'b0) begin
            failures++; $display("FAIL post_reset got=%0d lat=%0d rdata=%h err=%b exp=3/c0de0001/0", got, lat, rd, er);
        end
    endtask

    task automatic test_random();
        bit got, st; int lat, acc, su, w, elat, eacc; logic [31:0] rd, pwd, a, prd, wd, erd;
        logic er, prv, pw, we, serr, eer; logic [19:0] pa; logic [3:0] ps, be; bit inw;
        for (int t = 0; t < 40; t++) begin
            inw = ($urandom_range(0, 3) != 0);
            a = $urandom;
            if (inw) a = (a & ~MASK) | BASE;
            else if ((a & MASK) == BASE) a = a ^ 32'h8000_0000;
            we = 1'($urandom); be = 4'($urandom); wd = $urandom; prd = $urandom;
            serr = ($urandom_range(0, 4) == 0); w = $urandom_range(0, 6);
            model(a, we, w, prd, serr, elat, erd, eer, eacc);
            do_txn(a, we, be, wd, w, prd, serr, got, lat, rd, er, acc, su, st, prv, pa, pw, pwd, ps);
            checks++;
            if (!got || lat != elat || acc != eacc || rd !== erd || er !== eer) begin
                failures++;
                $display("FAIL rand_resp t=%0d addr=%h we=%b waits=%0d got=%0d lat=%0d/%0d acc=%0d/%0d rdata=%h/%h err=%b/%b",
                         t, a, we, w, got, lat, elat, acc, eacc, rd, erd, er, eer);
            end
            if (inw) begin
                checks++;
                if (pa !== a[19:0] || pw !== we || pwd !== wd || ps !== (we ? be : 4'h0) || !st || su != 1) begin
                    failures++;
                    $display("FAIL rand_apb t=%0d paddr=%h/%h pwrite=%b/%b pwdata=%h/%h pstrb=%h stable=%0d setup=%0d",
                             t, pa, a[19:0], pw, we, pwd, wd, ps, st, su);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_waits();
        test_out_of_window();
        test_timeout();
        test_slverr();
        test_back_to_back(32'h4000_0400, 4, "inwin");
        test_back_to_back(32'h9000_0000, 2, "oow");
        test_reset_during_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
